tick_rate_ctrl: RTL and testbench

- Controller for a fractional phase-accumulator tick generator (add-increment, subtract-modulus divider).
- Owns the accumulator and sequences it through idle, run and reconfiguration.
- Accepts rate configurations through a valid/ready handshake and applies a new rate only at a tick boundary, so no tick period is ever corrupted.
- Optionally stops after a programmed number of ticks; sits between the system clock and any logic needing a slow strobe (display scan, debounce, seconds counter).

---
 rtl/tick_rate_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tick_rate_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_rate_ctrl.sv
// Fractional phase-accumulator tick controller: idle/run/pend sequencing, handshaked
// rate reconfiguration applied on tick boundaries, optional auto-stop after N ticks.
// Optional square-wave output is built when TICK_RATE_CTRL_SQUARE_EN is defined.
module tick_rate_ctrl #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [ACC_W-1:0] cfg_mod,
  input  logic [CNT_W-1:0] cfg_count,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt,
  output logic             tick_sq
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  state_t           state, stateNx;
  logic [ACC_W-1:0] acc, accNx;
  logic [ACC_W-1:0] actInc, actIncNx, actMod, actModNx;
  logic [ACC_W-1:0] shInc, shIncNx, shMod, shModNx;
  logic [CNT_W-1:0] actCnt, actCntNx, shCnt, shCntNx;
  logic [CNT_W-1:0] tickCnt, tickCntNx, cntInc;
  logic             tickQ, tickNx, doneQ, doneNx, errQ, errNx;
  logic             hs, cfgOk, wrap, limitHit;
  logic [ACC_W:0]   sum;

  assign cfg_ready = (state != PEND);
  assign hs        = cfg_valid & cfg_ready;
  assign cfgOk     = (cfg_inc != '0) && (cfg_mod != '0) && (cfg_inc <= cfg_mod);
  // One extra bit so acc + inc cannot overflow before the modulus compare.
  assign sum       = {1'b0, acc} + {1'b0, actInc};
  assign wrap      = (sum >= {1'b0, actMod});
  assign cntInc    = (&tickCnt) ? tickCnt : tickCnt + CNT_W'(1);

  // NOTE: every next-state variable gets a default first so no latch is inferred.
  always_comb begin
    stateNx   = state;
    accNx     = acc;
    actIncNx  = actInc;
    actModNx  = actMod;
    actCntNx  = actCnt;
    shIncNx   = shInc;
    shModNx   = shMod;
    shCntNx   = shCnt;
    tickCntNx = tickCnt;
    tickNx    = 1'b0;
    doneNx    = 1'b0;
    errNx     = hs & ~cfgOk;
    limitHit  = 1'b0;
    case (state)
      IDLE: begin
        accNx = '0;
        if (hs && cfgOk) begin
          actIncNx = cfg_inc;
          actModNx = cfg_mod;
          actCntNx = cfg_count;
        end
        // A configuration accepted this same cycle is the one the run starts with.
        if (start && !stop && actModNx != '0) begin
          stateNx   = RUN;
          tickCntNx = '0;
        end
      end
      RUN, PEND: begin
        if (stop) begin
          stateNx = IDLE;
          accNx   = '0;
        end else begin
          accNx = wrap ? (sum[ACC_W-1:0] - actMod) : sum[ACC_W-1:0];
          if (wrap) begin
            tickNx    = 1'b1;
            tickCntNx = cntInc;
            limitHit  = (actCnt != '0) && (cntInc == actCnt);
          end
          if (limitHit) begin
            doneNx  = 1'b1;
            stateNx = IDLE;
            accNx   = '0;
          end else if (state == PEND) begin
            if (wrap) begin
              actIncNx  = shInc;
              actModNx  = shMod;
              actCntNx  = shCnt;
              accNx     = '0;
              tickCntNx = '0;
              stateNx   = RUN;
            end
          end else if (hs && cfgOk) begin
            shIncNx = cfg_inc;
            shModNx = cfg_mod;
            shCntNx = cfg_count;
            stateNx = PEND;
          end
        end
      end
      default: stateNx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      actInc  <= '0;
      actMod  <= '0;
      actCnt  <= '0;
      shInc   <= '0;
      shMod   <= '0;
      shCnt   <= '0;
      tickCnt <= '0;
      tickQ   <= 1'b0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      state   <= stateNx;
      acc     <= accNx;
      actInc  <= actIncNx;
      actMod  <= actModNx;
      actCnt  <= actCntNx;
      shInc   <= shIncNx;
      shMod   <= shModNx;
      shCnt   <= shCntNx;
      tickCnt <= tickCntNx;
      tickQ   <= tickNx;
      doneQ   <= doneNx;
      errQ    <= errNx;
    end
  end

  assign tick     = tickQ;
  assign done     = doneQ;
  assign cfg_err  = errQ;
  assign tick_cnt = tickCnt;
  assign busy     = (state != IDLE);

`ifdef TICK_RATE_CTRL_SQUARE_EN
  logic tickSqQ;
  // Entering or leaving IDLE (start, stop, auto-stop) resets the square-wave phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      tickSqQ <= 1'b0;
    else if ((state == IDLE) != (stateNx == IDLE)) tickSqQ <= 1'b0;
    else if (tickNx)                              tickSqQ <= ~tickSqQ;
  end
  assign tick_sq = tickSqQ;
`else
  assign tick_sq = 1'b0;
`endif

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed self-checking bench for tick_rate_ctrl: rate patterns, count limit,
// reconfiguration at tick boundary, invalid configs, stop on wrap, async reset.
module tb_tick_rate_ctrl;

`ifdef TICK_RATE_CTRL_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cfg_valid, start, stop;
  logic [31:0] cfg_inc, cfg_mod;
  logic [15:0] cfg_count;
  logic        cfg_ready, cfg_err, tick, busy, done, tick_sq;
  logic [15:0] tick_cnt;

  int checks = 0;
  int errors = 0;

  tick_rate_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_inc(cfg_inc), .cfg_mod(cfg_mod), .cfg_count(cfg_count), .cfg_err(cfg_err),
    .start(start), .stop(stop), .tick(tick), .busy(busy), .done(done),
    .tick_cnt(tick_cnt), .tick_sq(tick_sq)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Output bundle order: {tick, done, busy, cfg_ready, cfg_err, tick_sq}
  function automatic logic [5:0] outs();
    return {tick, done, busy, cfg_ready, cfg_err, tick_sq};
  endfunction

  task automatic offer(input logic [31:0] i, input logic [31:0] m, input logic [15:0] c);
    cfg_inc   = i;
    cfg_mod   = m;
    cfg_count = c;
    cfg_valid = 1'b1;
  endtask

  task automatic load_and_start(input logic [31:0] i, input logic [31:0] m, input logic [15:0] c);
    offer(i, m, c);
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    checks++;
    if (outs() !== 6'b000100) begin
      errors++;
      $display("FAIL reset_outs got %b exp %b", outs(), 6'b000100);
    end
    checks++;
    if (tick_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d exp 0", tick_cnt);
    end
    rst = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_mod0 busy got %b exp 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [5:0]  exp;
    logic [15:0] ec;
    offer(32'd1, 32'd4, 16'd0);
    cyc();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_cfg_err got %b exp 0", cfg_err);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      ec  = 16'(i / 4);
      exp = {(i % 4 == 0), 1'b0, 1'b1, 1'b1, 1'b0, SQ_EN & ec[0]};
      checks++;
      if (outs() !== exp || tick_cnt !== ec) begin
        errors++;
        $display("FAIL basic[%0d] got %b/%0d exp %b/%0d", i, outs(), tick_cnt, exp, ec);
      end
    end
    do_stop();
    checks++;
    if (outs() !== 6'b000100 || tick_cnt !== 16'd3) begin
      errors++;
      $display("FAIL basic_stop got %b/%0d exp 000100/3", outs(), tick_cnt);
    end
  endtask

  task automatic test_fractional();
    logic        et;
    logic [15:0] ec = 16'd0;
    int          inWindow = 0;
    load_and_start(32'd3, 32'd8, 16'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      et = (i % 8 == 3) || (i % 8 == 6) || (i % 8 == 0);
      if (et) ec++;
      if (et && i <= 8) inWindow++;
      checks++;
      if (tick !== et || tick_cnt !== ec || tick_sq !== (SQ_EN & ec[0])) begin
        errors++;
        $display("FAIL frac[%0d] tick/cnt/sq got %b/%0d/%b exp %b/%0d/%b",
                 i, tick, tick_cnt, tick_sq, et, ec, SQ_EN & ec[0]);
      end
    end
    checks++;
    if (tick_cnt !== 16'd6 || inWindow != 3) begin
      errors++;
      $display("FAIL frac_total got %0d exp 6", tick_cnt);
    end
    do_stop();
  endtask

  task automatic test_count_limit();
    // Configuration and start in the same cycle: the new config must be used.
    offer(32'd1, 32'd2, 16'd5);
    start = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      checks++;
      if (tick !== (i % 2 == 0) || done !== (i == 10) || tick_cnt !== 16'(i / 2)) begin
        errors++;
        $display("FAIL count[%0d] tick/done/cnt got %b/%b/%0d exp %b/%b/%0d",
                 i, tick, done, tick_cnt, (i % 2 == 0), (i == 10), i / 2);
      end
      if (i < 10) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL count_busy[%0d] got %b exp 1", i, busy);
        end
      end
    end
    for (int i = 11; i <= 12; i++) begin
      cyc();
      checks++;
      if (outs() !== 6'b000100 || tick_cnt !== 16'd5) begin
        errors++;
        $display("FAIL count_after[%0d] got %b/%0d exp 000100/5", i, outs(), tick_cnt);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [5:0]  exp;
    logic [15:0] ec = 16'd0;
    int          nt = 0;
    logic        et, er;
    load_and_start(32'd1, 32'd10, 16'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) offer(32'd1, 32'd3, 16'd0);
      if (i == 5) cfg_valid = 1'b0;
      cyc();
      et = (i == 10) || (i == 13) || (i == 16);
      er = !(i >= 4 && i < 10);
      if (et) nt++;
      ec  = (i >= 16) ? 16'd2 : (i >= 13) ? 16'd1 : 16'd0;
      exp = {et, 1'b0, 1'b1, er, 1'b0, SQ_EN & nt[0]};
      checks++;
      if (outs() !== exp || tick_cnt !== ec) begin
        errors++;
        $display("FAIL reconfig[%0d] got %b/%0d exp %b/%0d", i, outs(), tick_cnt, exp, ec);
      end
    end
    do_stop();
  endtask

  task automatic test_invalid_cfg();
    logic [5:0]  exp;
    logic [15:0] ec;
    load_and_start(32'd1, 32'd4, 16'd0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 2) offer(32'd5, 32'd4, 16'd0);
      if (i == 3) cfg_valid = 1'b0;
      if (i == 6) offer(32'd0, 32'd4, 16'd0);
      if (i == 7) cfg_valid = 1'b0;
      cyc();
      ec  = 16'(i / 4);
      exp = {(i % 4 == 0), 1'b0, 1'b1, 1'b1, (i == 2) || (i == 6), SQ_EN & ec[0]};
      checks++;
      if (outs() !== exp || tick_cnt !== ec) begin
        errors++;
        $display("FAIL invalid[%0d] got %b/%0d exp %b/%0d", i, outs(), tick_cnt, exp, ec);
      end
    end
    do_stop();
  endtask

  task automatic test_stop_on_wrap();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (outs() !== 6'b000100 || tick_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stop_wrap got %b/%0d exp 000100/0", outs(), tick_cnt);
    end
    cyc();
    checks++;
    if (tick !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_wrap_after tick/busy got %b/%b exp 0/0", tick, busy);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    checks++;
    if (tick_cnt !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre cnt/busy got %0d/%b exp 1/1", tick_cnt, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 6'b000100 || tick_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_async got %b/%0d exp 000100/0", outs(), tick_cnt);
    end
    cyc();
    rst = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_cleared_cfg busy/tick got %b/%b exp 0/0", busy, tick);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_inc = '0;
    cfg_mod = '0;
    cfg_count = '0;
    start = 1'b0;
    stop = 1'b0;
    test_reset();
    test_basic();
    test_fractional();
    test_count_limit();
    test_reconfig();
    test_invalid_cfg();
    test_stop_on_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
